sqrt_datapath: RTL and testbench

- Integer square-root datapath for the pipelined odd-number-subtraction square-root unit.
- Sits directly downstream of the square-root control path: it consumes `wr_input`, `en_pipe` and `mux_root`, and returns the negative flag `N`.
- Algorithm: subtract 1, 3, 5, … from the operand until the remainder goes negative; the root is the number of successful subtractions.
- Two register stages: iterate, then flag/sample. The flag therefore lags the arithmetic by one cycle, which the controller's drain states absorb.

---
 rtl/sqrt_pkg.sv | 11 +
 rtl/sqrt_datapath_if.sv | 23 ++
 rtl/sqrt_iter_stage.sv | 48 ++++
 rtl/sqrt_datapath.sv | 59 +++++
 tb/tb_sqrt_datapath.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Shared sizing for the odd-number-subtraction square-root datapath.
//   SQRT_WIDTH : default operand width (even, >= 4)
//   SQRT_RW    : root width
//   SQRT_DW    : remainder / odd-term width (two guard bits for the sign)
//   SQRT_KW    : iteration counter width (one bit over the root, for peak k = 2^RW)
package sqrt_pkg;
  localparam int SQRT_WIDTH = 8;
  localparam int SQRT_RW    = SQRT_WIDTH / 2;
  localparam int SQRT_DW    = SQRT_WIDTH + 2;
  localparam int SQRT_KW    = SQRT_RW + 1;
endpackage

// File: rtl/sqrt_datapath_if.sv
// Controller <-> square-root datapath bundle.
//   x_i        : operand, sampled on wr_input_i
//   wr_input_i : load operand / restart iteration
//   en_pipe_i  : advance both pipeline stages
//   mux_root_i : 1 freezes the root register
//   N_o        : registered remainder sign (1 = subtraction overshot)
//   root_o     : floor(sqrt(x))
// master = controller side, slave = datapath side.
interface sqrt_datapath_if #(
  parameter int WIDTH = sqrt_pkg::SQRT_WIDTH
);
  logic [WIDTH-1:0]   x_i;
  logic               wr_input_i;
  logic               en_pipe_i;
  logic               mux_root_i;
  logic               N_o;
  logic [WIDTH/2-1:0] root_o;

  modport master (output x_i, wr_input_i, en_pipe_i, mux_root_i,
                  input  N_o, root_o);
  modport slave  (input  x_i, wr_input_i, en_pipe_i, mux_root_i,
                  output N_o, root_o);
endinterface

// File: rtl/sqrt_iter_stage.sv
// Stage 1 of the square-root datapath: subtracts 1, 3, 5, ... from the
// operand, counting successful steps, and holds once the remainder goes
// negative.
//   clk, rst_n : clock, async active-low reset
//   x          : operand
//   load       : load operand (priority over en)
//   en         : advance one iteration
//   d_neg      : remainder sign bit
//   k          : number of subtractions performed
module sqrt_iter_stage
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     x,
  input  logic                 load,
  input  logic                 en,
  output logic                 d_neg,
  output logic [WIDTH/2:0]     k
);
  localparam int DW = WIDTH + 2;
  localparam int KW = WIDTH / 2 + 1;

  // Two's-complement remainder kept as a plain vector; the MSB is the sign.
  logic [DW-1:0] d;
  logic [DW-1:0] odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d   <= '0;
      odd <= DW'(1);
      k   <= '0;
    end else if (load) begin
      d   <= {2'b00, x};
      odd <= DW'(1);
      k   <= '0;
    end else if (en && !d[DW-1]) begin
      // Sticky: once negative nothing moves, so k peaks at root+1.
      d   <= d - odd;
      odd <= odd + DW'(2);
      k   <= k + KW'(1);
    end
  end

  assign d_neg = d[DW-1];
endmodule

// File: rtl/sqrt_datapath.sv
// Integer square-root datapath. Stage 1 (sqrt_iter_stage) iterates; stage 2
// samples the sign and count one cycle later; the root register takes
// count-1 while mux_root_i = 0, which is correct at the edge where the
// controller sees N_o = 1.
//   clk, rst_n : clock, async active-low reset
//   bus        : sqrt_datapath_if slave (x_i, wr_input_i, en_pipe_i,
//                mux_root_i in; N_o, root_o out)
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  sqrt_datapath_if.slave  bus
);
  localparam int RW = WIDTH / 2;
  localparam int KW = RW + 1;

  logic          d_neg;
  logic [KW-1:0] k;
  logic          n_q;
  logic [KW-1:0] k_q;
  logic [RW-1:0] root_q;

  sqrt_iter_stage #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (bus.x_i),
    .load  (bus.wr_input_i),
    .en    (bus.en_pipe_i),
    .d_neg (d_neg),
    .k     (k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      k_q <= '0;
    end else if (bus.wr_input_i) begin
      n_q <= 1'b0;
      k_q <= '0;
    end else if (bus.en_pipe_i) begin
      n_q <= d_neg;
      k_q <= k;
    end
  end

  // k_q overshoots by one (it counts the failing subtraction too).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      root_q <= '0;
    else if (bus.en_pipe_i && !bus.mux_root_i && !bus.wr_input_i)
      root_q <= RW'(k_q - KW'(1));
  end

  assign bus.N_o    = n_q;
  assign bus.root_o = root_q;
endmodule

// File: tb/tb_sqrt_datapath.sv
// Scoreboard bench for sqrt_datapath: the driver pushes the expected root
// and N_o rise point per operand; a negedge monitor pops on each N_o rise.
module tb_sqrt_datapath;
  localparam int W = 8;

  typedef struct {
    int root;
    int rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sqrt_datapath_if #(.WIDTH(W)) bus ();
  sqrt_datapath #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_edges = 0;
  bit   pend = 0;
  exp_t cur;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Remainder after k successful subtractions is x - k^2 (10-bit view).
  function automatic int ref_d(input int x, input int k);
    logic [W+1:0] v;
    v = (W + 2)'(x - k * k);
    return int'(v);
  endfunction

  // Monitor
  initial begin
    bit n_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_prev = 0;
        pend   = 0;
      end else begin
        if (bus.N_o && !n_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_n_rise", 1, 0);
          end else begin
            cur = sb.pop_front();
            check("n_rise_edge", en_edges, cur.rise);
            pend = 1;
          end
        end
        if (pend && en_edges >= cur.rise + 1) begin
          check("root", int'(bus.root_o), cur.root);
          pend = 0;
        end
        n_prev = bus.N_o;
      end
    end
  end

  task automatic tick(input bit en);
    bus.en_pipe_i = en;
    @(posedge clk);
    #1;
    if (en) en_edges++;
  endtask

  task automatic load(input int x);
    bus.x_i        = W'(x);
    bus.wr_input_i = 1'b1;
    bus.en_pipe_i  = 1'($urandom_range(1));
    bus.mux_root_i = 1'b0;
    @(posedge clk);
    #1;
    bus.wr_input_i = 1'b0;
    en_edges = 0;
  endtask

  // mode 0: continuous enable, 1: random idle cycles,
  // 2: three idle cycles after the 5th edge with hold checks
  task automatic run_txn(input int x, input int mode);
    exp_t e;
    int   r;
    int   cyc = 0;
    r = ref_root(x);
    e.root = r;
    e.rise = r + 2;
    sb.push_back(e);
    load(x);
    while (en_edges < r + 5 && cyc < 400) begin
      cyc++;
      if (mode == 2 && en_edges == 5) begin
        for (int i = 0; i < 3; i++) begin
          tick(1'b0);
          check("hold_d", int'(dut.u_iter.d), ref_d(x, 5));
          check("hold_n", int'(bus.N_o), 0);
        end
        mode = 0;
      end
      tick(mode == 1 ? ($urandom_range(3) != 0) : 1'b1);
    end
    @(negedge clk);
    #1;
    check("txn_complete", sb.size() + int'(pend), 0);
    sb.delete();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.x_i        = '0;
    bus.wr_input_i = 1'b0;
    bus.en_pipe_i  = 1'b0;
    bus.mux_root_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_n", int'(bus.N_o), 0);
    check("reset_root", int'(bus.root_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn(16, 0);
    run_txn(0, 0);
    run_txn(255, 0);
    // Freeze root while the stages keep clocking.
    bus.mux_root_i = 1'b1;
    repeat (10) tick(1'b1);
    check("freeze_root", int'(bus.root_o), 15);
    check("freeze_n", int'(bus.N_o), 1);
    check("freeze_d", int'(dut.u_iter.d), ref_d(255, 16));
    bus.mux_root_i = 1'b0;

    run_txn(15, 0);
    run_txn(24, 0);

    // Reset in the middle of an iteration.
    load(200);
    repeat (5) tick(1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_n", int'(bus.N_o), 0);
    check("midrst_root", int'(bus.root_o), 0);
    check("midrst_d", int'(dut.u_iter.d), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_txn(200, 0);

    run_txn(100, 2);

    for (int i = 0; i < 30; i++)
      run_txn(int'($urandom_range(255)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
